// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table response checker.
package tt_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Index of the lowest set bit of a mismatch mask; 0 when the mask is empty.
    function automatic logic [VEC_W-1:0] lowest_set(input logic [NUM_VECTORS-1:0] mask);
        lowest_set = '0;
        for (int unsigned i = NUM_VECTORS; i > 0; i--) begin
            if (mask[i-1]) lowest_set = VEC_W'(i - 1);
        end
    endfunction

endpackage

// File: rtl/tt_response_checker_settle_timer.sv
// Per-vector hold counter: load restarts the hold window, expire marks the
// last settle cycle so the FSM can move to sampling on the next edge.
module settle_timer
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    logic [3:0] cnt_q, cnt_d;

    // Next count: reload on a new vector, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 4'(SETTLE_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Remaining-settle-cycles register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q <= 4'd1);

endmodule

// File: rtl/tt_response_checker.sv
// Exhaustive 3-input truth-table checker: drives vectors 000..111, holds each
// for SETTLE_CYCLES cycles, samples z on the last cycle and compares the
// observed table against the table latched at start.
module tt_response_checker
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    input  logic                   z,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] captured,
    output logic [VEC_W-1:0]       first_fail
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);
    // A one-cycle hold has no settle phase: every cycle is a sample cycle.
    localparam state_t VEC_ENTRY = (SETTLE_CYCLES == 1) ? ST_SAMPLE : ST_SETTLE;

    state_t                 state_q;
    logic [VEC_W-1:0]       vec_q;
    logic [VEC_W-1:0]       abc_q;
    logic [NUM_VECTORS-1:0] exp_q;
    logic [NUM_VECTORS-1:0] captured_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic [VEC_W-1:0]       first_fail_q;
    logic                   load;
    logic                   expire;

    // Restart the hold window whenever a new vector is presented.
    always_comb begin
        load = 1'b0;
        if (state_q == ST_IDLE && start) load = 1'b1;
        if (state_q == ST_SAMPLE && vec_q != LAST_VEC) load = 1'b1;
    end

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .expire(expire)
    );

    // Run sequencing FSM with registered outputs; a/b/c come straight from a
    // register so vector changes are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            abc_q        <= '0;
            exp_q        <= '0;
            captured_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            first_fail_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= VEC_ENTRY;
                        exp_q        <= expected;
                        captured_q   <= '0;
                        vec_q        <= '0;
                        abc_q        <= '0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        first_fail_q <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (expire) state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    captured_q[vec_q] <= z;
                    if (vec_q == LAST_VEC) begin
                        state_q <= ST_DONE;
                        vec_q   <= '0;
                        abc_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= VEC_ENTRY;
                        vec_q   <= vec_q + VEC_W'(1);
                        abc_q   <= vec_q + VEC_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q       <= 1'b1;
                    pass_q       <= (captured_q == exp_q);
                    first_fail_q <= lowest_set(captured_q ^ exp_q);
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign a          = abc_q[2];
    assign b          = abc_q[1];
    assign c          = abc_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign captured   = captured_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Scoreboard bench: stimulus pushes hand-computed run results, negedge
// monitors pop and compare on done and check a/b/c and busy every cycle.
module tb_tt_response_checker;

    localparam int S1 = 2;
    localparam int S2 = 1;

    typedef struct {
        logic [7:0] cap;
        logic       pass;
        logic [2:0] ff;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2;
    logic [7:0] exp1, exp2;
    logic       z1, z2;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic       a2, b2, c2, busy2, done2, pass2;
    logic [7:0] cap1, cap2;
    logic [2:0] ff1, ff2;
    int unsigned mode1;
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    exp_t       q1[$];
    exp_t       q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: NOR, 1: stuck at 0, 2: NOR but z=1 at vector 6
    always_comb begin
        z1 = ~(a1 | b1 | c1);
        if (mode1 == 1) z1 = 1'b0;
        if (mode1 == 2 && {a1, b1, c1} == 3'd6) z1 = 1'b1;
        z2 = ~(a2 | b2 | c2);
    end

    tt_response_checker #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1), .z(z1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .first_fail(ff1)
    );

    tt_response_checker #(.SETTLE_CYCLES(S2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .expected(exp2), .z(z2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
        .captured(cap2), .first_fail(ff2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // DUT1 monitor
    always @(negedge clk) begin
        int d;
        int ev;
        exp_t e;
        if (!rst) begin
            if (q1.size() > 0) begin
                d  = cyc - q1[0].acc;
                ev = (d >= 0 && d < 8 * S1) ? d / S1 : 0;
                check("abc1", {29'd0, a1, b1, c1}, ev);
                check("busy1", busy1, (d >= 0 && d < 8 * S1));
            end
            if (done1) begin
                if (q1.size() == 0) begin
                    check("extra_done1", done1, 0);
                end else begin
                    e = q1.pop_front();
                    check("done_cycle1", cyc, e.acc + 8 * S1 + 1);
                    check("captured1", cap1, e.cap);
                    check("pass1", pass1, e.pass);
                    check("first_fail1", ff1, e.ff);
                end
            end
        end
    end

    // DUT2 monitor
    always @(negedge clk) begin
        int d;
        int ev;
        exp_t e;
        if (!rst) begin
            if (q2.size() > 0) begin
                d  = cyc - q2[0].acc;
                ev = (d >= 0 && d < 8 * S2) ? d / S2 : 0;
                check("abc2", {29'd0, a2, b2, c2}, ev);
                check("busy2", busy2, (d >= 0 && d < 8 * S2));
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    check("extra_done2", done2, 0);
                end else begin
                    e = q2.pop_front();
                    check("done_cycle2", cyc, e.acc + 8 * S2 + 1);
                    check("captured2", cap2, e.cap);
                    check("pass2", pass2, e.pass);
                    check("first_fail2", ff2, e.ff);
                end
            end
        end
    end

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (q1.size() > 0 || q2.size() > 0); i++) @(negedge clk);
        @(negedge clk);
        check("drain1", q1.size(), 0);
        check("drain2", q2.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dut1"}, {a1, b1, c1, busy1, done1, pass1, cap1, ff1}, 0);
        check({tag, "_dut2"}, {a2, b2, c2, busy2, done2, pass2, cap2, ff2}, 0);
    endtask

    task automatic run1(input logic [7:0] e, input int unsigned m, input logic [7:0] cap,
                        input logic p, input logic [2:0] ff, input bit ign_start, input bit chg_exp);
        exp_t x;
        @(negedge clk);
        mode1  = m;
        exp1   = e;
        start1 = 1'b1;
        x.acc  = cyc + 1;
        x.cap  = cap;
        x.pass = p;
        x.ff   = ff;
        q1.push_back(x);
        @(negedge clk);
        start1 = 1'b0;
        if (chg_exp) exp1 = ~e;
        if (ign_start) begin
            repeat (5) @(negedge clk);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
        end
        drain(60);
    endtask

    initial begin
        exp_t x;
        int   a0;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        exp1 = 8'h00; exp2 = 8'h00; mode1 = 0;

        // reset state, with start requests ignored while rst is high
        repeat (2) @(negedge clk);
        start1 = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        start1 = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("idle");

        // good case, stuck fault, late fault
        run1(8'h01, 0, 8'h01, 1'b1, 3'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_captured1", cap1, 8'h01);
        check("hold_pass1", pass1, 1'b1);
        run1(8'h01, 1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        run1(8'h01, 2, 8'h41, 1'b0, 3'd6, 1'b0, 1'b0);
        // ignored start mid-run, and expected changed after being latched
        run1(8'h01, 0, 8'h01, 1'b1, 3'd0, 1'b1, 1'b1);

        // reset during vector 4
        @(negedge clk);
        mode1 = 0; exp1 = 8'h01; start1 = 1'b1;
        x.acc = cyc + 1; x.cap = 8'h01; x.pass = 1'b1; x.ff = 3'd0;
        q1.push_back(x);
        @(negedge clk);
        start1 = 1'b0;
        repeat (8) @(negedge clk);
        check("vec4_before_reset", {a1, b1, c1}, 3'd4);
        @(posedge clk);
        #3;
        rst = 1'b1;
        q1.delete();
        #1;
        check_zero("midrun_reset");
        start1 = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_in_reset", busy1, 1'b0);
        rst = 1'b0;
        x.acc = cyc + 1;
        q1.push_back(x);
        @(negedge clk);
        start1 = 1'b0;
        drain(60);

        // back-to-back runs with start held high on the one-cycle instance
        @(negedge clk);
        exp2 = 8'h01; start2 = 1'b1;
        a0 = cyc + 1;
        for (int r = 0; r < 3; r++) begin
            x.acc = a0 + 10 * r; x.cap = 8'h01; x.pass = 1'b1; x.ff = 3'd0;
            q2.push_back(x);
        end
        repeat (30) @(negedge clk);
        start2 = 1'b0;
        drain(60);
        repeat (3) @(negedge clk);
        check("no_extra_run2", busy2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach summary, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
